sub_bytes_engine: RTL

Parametrised, iterative AES SubBytes / InvSubBytes engine for a full LENGTH-bit state. A configurable number of S-box lanes is time-multiplexed over the state, trading area for latency. Valid/ready handshakes sit on both sides. It replaces fixed 4-lane word substitution in the cipher datapath and is shared by the round logic and key expansion.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/sub_bytes_engine_if.sv | 18 +
 rtl/sub_bytes_engine_sbox_lane.sv | 12 +
 rtl/sub_bytes_engine.sv | 110 +++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: symbol width, forward/inverse S-box tables and engine FSM states.
// Tables are flattened with entry 0 in the most significant byte.
package aes_pkg;

    localparam int BYTE = 8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
        int idx;
        idx = 255 - int'(b);
        sbox_lookup = inv ? SBOX_INV[idx*8 +: 8] : SBOX_FWD[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/sub_bytes_engine_if.sv
// Block-level handshake bundle for the SubBytes engine: one input and one output channel.
interface sub_bytes_engine_if #(parameter int LENGTH = 128);
    // A channel transfers on a rising edge where valid and ready are both high; once
    // valid is raised it and its payload stay put until that edge, and ready never
    // depends on valid.
    logic              in_valid;
    logic              in_ready;
    logic              inv;
    logic [LENGTH-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [LENGTH-1:0] out_data;

    modport master (output in_valid, inv, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, inv, in_data, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/sub_bytes_engine_sbox_lane.sv
// One S-box lane: forward or inverse byte substitution selected by inv.
module sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] in,
    input  logic       inv,
    output logic [7:0] out
);
    always_comb begin
        out = sbox_lookup(in, inv);
    end
endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative SubBytes/InvSubBytes engine: LANES S-boxes sweep the state over BEATS cycles
// between a capture register and a byte-enabled result register.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LENGTH = 128,
    parameter int LANES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    sub_bytes_engine_if.slave   bus,
    output state_t              dbg_state
);
    localparam int W     = BYTE * LANES;
    localparam int BEATS = LENGTH / W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (LANES < 1 || (LENGTH % (BYTE * LANES)) != 0) begin : g_bad_cfg
        $error("sub_bytes_engine: LENGTH must be a multiple of BYTE*LANES and LANES >= 1");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic [LENGTH-1:0]  src_q, src_d;
    logic [LENGTH-1:0]  out_q, out_d;
    logic [W-1:0]       src_word;
    logic [W-1:0]       sub_word;
    logic               in_ready_c;
    logic               out_valid_c;

    always_comb begin
        src_word = src_q[int'(cnt_q)*W +: W];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sbox_lane u_lane (
            .in  (src_word[l*BYTE +: BYTE]),
            .inv (mode_q),
            .out (sub_word[l*BYTE +: BYTE])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        src_d       = src_q;
        out_d       = out_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    src_d   = bus.in_data;
                    mode_d  = bus.inv;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                out_d[int'(cnt_q)*W +: W] = sub_word;
                if (cnt_q == CNT_W'(BEATS - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                // Draining and refilling share one edge, so a waiting block loses no cycle.
                in_ready_c  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        src_d   = bus.in_data;
                        mode_d  = bus.inv;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            src_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            out_q   <= out_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_q;
    assign dbg_state     = state_q;
endmodule
